// File: rtl/axis_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection arbiter: default widths and the lock FSM states.
package axis_inject_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATAW_DEFAULT   = 512;
    localparam int USERW_DEFAULT   = 75;
    localparam int DESTW_DEFAULT   = 12;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_inject_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above the pointer, wrapping around.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    ptr_i,
    output logic [IDXW-1:0]    grant_o,
    output logic               any_req_o
);

    logic [IDXW-1:0] cand;

    // The pointer names the last winner, so the search starts one above it.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDXW'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_req_o && req_i[cand]) begin
                any_req_o = 1'b1;
                grant_o   = cand;
            end
        end
    end

endmodule

// File: rtl/axis_inject_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_REQ AXI-Stream sources into one
// NoC injection port through a single output register stage.
module axis_inject_arbiter
    import axis_inject_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEFAULT,
    parameter int  DATAW   = DATAW_DEFAULT,
    parameter int  USERW   = USERW_DEFAULT,
    parameter int  DESTW   = DESTW_DEFAULT,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       AXIS_S_TVALID,
    output logic [NUM_REQ-1:0]       AXIS_S_TREADY,
    input  logic [NUM_REQ*DATAW-1:0] AXIS_S_TDATA,
    input  logic [NUM_REQ-1:0]       AXIS_S_TLAST,
    input  logic [NUM_REQ*USERW-1:0] AXIS_S_TUSER,
    input  logic [NUM_REQ*DESTW-1:0] AXIS_S_TDEST,
    output logic                     AXIS_M_TVALID,
    input  logic                     AXIS_M_TREADY,
    output logic [DATAW-1:0]         AXIS_M_TDATA,
    output logic                     AXIS_M_TLAST,
    output logic [USERW-1:0]         AXIS_M_TUSER,
    output logic [DESTW-1:0]         AXIS_M_TDEST,
    output logic [IDXW-1:0]          GRANT_ID,
    output logic                     BUSY
);

    arb_state_t      state_q;
    logic [IDXW-1:0] grant_q, rr_ptr_q, pick;
    logic            busy_q, any_req;

    logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATAW-1:0] m_data_q, m_data_d;
    logic [USERW-1:0] m_user_q, m_user_d;
    logic [DESTW-1:0] m_dest_q, m_dest_d;

    logic             sel_valid, sel_last;
    logic [DATAW-1:0] sel_data;
    logic [USERW-1:0] sel_user;
    logic [DESTW-1:0] sel_dest;
    logic             s_ready, s_hs, m_hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i     (AXIS_S_TVALID),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        sel_dest  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDXW'(i)) begin
                sel_valid = AXIS_S_TVALID[i];
                sel_last  = AXIS_S_TLAST[i];
                sel_data  = AXIS_S_TDATA[i*DATAW +: DATAW];
                sel_user  = AXIS_S_TUSER[i*USERW +: USERW];
                sel_dest  = AXIS_S_TDEST[i*DESTW +: DESTW];
            end
        end
    end

    // Only the locked source may see ready, and only when the output slot frees up this cycle.
    assign s_ready = (state_q == LOCKED) && (!m_valid_q || AXIS_M_TREADY);
    assign s_hs    = s_ready && sel_valid;
    assign m_hs    = m_valid_q && AXIS_M_TREADY;

    always_comb begin
        AXIS_S_TREADY = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            AXIS_S_TREADY[i] = s_ready && (grant_q == IDXW'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDXW'(NUM_REQ - 1);
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (s_hs && sel_last) begin
                        rr_ptr_q <= grant_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A load always wins over a drain, so back-to-back beats keep valid high.
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_dest_d  = m_dest_q;
        if (s_hs) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_data_d  = sel_data;
            m_user_d  = sel_user;
            m_dest_d  = sel_dest;
        end else if (m_hs) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_dest_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_dest_q  <= m_dest_d;
        end
    end

    assign AXIS_M_TVALID = m_valid_q;
    assign AXIS_M_TLAST  = m_last_q;
    assign AXIS_M_TDATA  = m_data_q;
    assign AXIS_M_TUSER  = m_user_q;
    assign AXIS_M_TDEST  = m_dest_q;
    assign GRANT_ID      = grant_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// Scoreboard bench for axis_inject_arbiter: packets are queued per requester, the expected
// output order is derived from round-robin-over-whole-packets, and a monitor pops and compares.
module tb_axis_inject_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int UW   = 8;
   localparam int TW   = 4;
   localparam int IW   = 2;
   localparam int MAXB = 64;

   logic                 CLK = 1'b0;
   logic                 RST_N;
   logic [NREQ-1:0]      sTValid, sTReady, sTLast;
   logic [NREQ*DW-1:0]   sTData;
   logic [NREQ*UW-1:0]   sTUser;
   logic [NREQ*TW-1:0]   sTDest;
   logic                 mTValid, mTReady, mTLast;
   logic [DW-1:0]        mTData;
   logic [UW-1:0]        mTUser;
   logic [TW-1:0]        mTDest;
   logic [IW-1:0]        grantId;
   logic                 busy;

   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [TW-1:0] dest;
      logic          last;
      int            gap;
   } beat_t;

   beat_t           srcBeats [NREQ][MAXB];
   int              srcCount [NREQ];
   int              srcPos   [NREQ];
   int              gapCnt   [NREQ];
   logic [NREQ-1:0] inPkt;
   beat_t           expQ [$];

   int   vecCount, errCount, cycleCnt, popCount, stallCycles;
   int   firstValidCycle, firstMCycle, lastPopCycle, mReadyPct;
   logic drvEnable, forceStall;

   axis_inject_arbiter #(.NUM_REQ(NREQ), .DATAW(DW), .USERW(UW), .DESTW(TW)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .AXIS_S_TVALID (sTValid),
      .AXIS_S_TREADY (sTReady),
      .AXIS_S_TDATA  (sTData),
      .AXIS_S_TLAST  (sTLast),
      .AXIS_S_TUSER  (sTUser),
      .AXIS_S_TDEST  (sTDest),
      .AXIS_M_TVALID (mTValid),
      .AXIS_M_TREADY (mTReady),
      .AXIS_M_TDATA  (mTData),
      .AXIS_M_TLAST  (mTLast),
      .AXIS_M_TUSER  (mTUser),
      .AXIS_M_TDEST  (mTDest),
      .GRANT_ID      (grantId),
      .BUSY          (busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic addBeat(input int req, input logic [DW-1:0] data, input logic [UW-1:0] user,
                          input logic [TW-1:0] dest, input logic last, input int gap);
      srcBeats[req][srcCount[req]].data = data;
      srcBeats[req][srcCount[req]].user = user;
      srcBeats[req][srcCount[req]].dest = dest;
      srcBeats[req][srcCount[req]].last = last;
      srcBeats[req][srcCount[req]].gap  = gap;
      srcCount[req]++;
   endtask

   // Queue one random packet; gapIdx (>=1) names a beat preceded by gapLen idle cycles.
   task automatic applyStimulus(input int req, input int len, input int gapIdx, input int gapLen);
      for (int b = 0; b < len; b++) begin
         addBeat(req, DW'($urandom), UW'($urandom_range(255)), TW'($urandom_range(15)),
                 (b == len - 1), (b == gapIdx) ? gapLen : 0);
      end
   endtask

   // Reference order: after reset the last winner is NUM_REQ-1; each decision picks the first
   // requester above the last winner that still owns a packet and sends that packet whole.
   task automatic buildExpected();
      int   cur [NREQ];
      int   ptr;
      bit   found;
      for (int i = 0; i < NREQ; i++) cur[i] = 0;
      ptr   = NREQ - 1;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (!found && cur[idx] < srcCount[idx]) begin
               bit done;
               found = 1'b1;
               ptr   = idx;
               done  = 1'b0;
               while (!done) begin
                  expQ.push_back(srcBeats[idx][cur[idx]]);
                  done = srcBeats[idx][cur[idx]].last;
                  cur[idx]++;
               end
            end
         end
      end
   endtask

   task automatic clearSources();
      for (int i = 0; i < NREQ; i++) begin
         srcCount[i] = 0;
         srcPos[i]   = 0;
         gapCnt[i]   = 0;
      end
      inPkt           = '0;
      expQ.delete();
      popCount        = 0;
      stallCycles     = 0;
      firstValidCycle = -1;
      firstMCycle     = -1;
      lastPopCycle    = -1;
   endtask

   task automatic applyReset();
      drvEnable  = 1'b0;
      forceStall = 1'b0;
      @(posedge CLK);
      #2 RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      clearSources();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   function automatic bit sourcesPending();
      bit p = 1'b0;
      for (int i = 0; i < NREQ; i++) if (srcPos[i] < srcCount[i]) p = 1'b1;
      return p;
   endfunction

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while ((expQ.size() != 0 || sourcesPending()) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checkOutput({name, "_drain_timeout"}, 64'(n >= budget), 64'(0));
      repeat (3) @(negedge CLK);
   endtask

   task automatic waitFirstPop(input string name);
      int n = 0;
      while (popCount < 1 && n < 100) begin
         @(negedge CLK);
         #1;
         n++;
      end
      checkOutput({name, "_first_beat_timeout"}, 64'(n >= 100), 64'(0));
   endtask

   // Source driver: learns handshakes at the falling edge, updates all inputs just after the rising edge.
   task automatic driverLoop();
      logic [NREQ-1:0] hsv;
      forever begin
         @(negedge CLK);
         hsv = (RST_N && drvEnable) ? (sTValid & sTReady) : '0;
         @(posedge CLK);
         cycleCnt++;
         #1;
         if (!drvEnable) begin
            sTValid = '0;
            mTReady = 1'b0;
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               if (hsv[i]) begin
                  inPkt[i] = !srcBeats[i][srcPos[i]].last;
                  srcPos[i]++;
                  if (inPkt[i] && srcPos[i] < srcCount[i]) gapCnt[i] = srcBeats[i][srcPos[i]].gap;
               end
               if (gapCnt[i] > 0) begin
                  sTValid[i] = 1'b0;
                  gapCnt[i]--;
               end else begin
                  sTValid[i] = (srcPos[i] < srcCount[i]);
               end
               if (srcPos[i] < srcCount[i]) begin
                  sTData[i*DW +: DW] = srcBeats[i][srcPos[i]].data;
                  sTUser[i*UW +: UW] = srcBeats[i][srcPos[i]].user;
                  sTDest[i*TW +: TW] = srcBeats[i][srcPos[i]].dest;
                  sTLast[i]          = srcBeats[i][srcPos[i]].last;
               end else begin
                  sTData[i*DW +: DW] = '0;
                  sTUser[i*UW +: UW] = '0;
                  sTDest[i*TW +: TW] = '0;
                  sTLast[i]          = 1'b0;
               end
            end
            if (sTValid != '0 && firstValidCycle < 0) firstValidCycle = cycleCnt;
            mTReady = forceStall ? 1'b0 : (int'($urandom_range(99)) < mReadyPct);
         end
      end
   endtask

   // Output monitor: protocol rules every cycle, scoreboard pop on every master handshake.
   task automatic monitorLoop();
      logic        stallPrev;
      logic [63:0] saved;
      beat_t       e;
      stallPrev = 1'b0;
      saved     = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N || !drvEnable) begin
            stallPrev = 1'b0;
         end else begin
            if (stallPrev) checkOutput("stall_hold", {18'd0, mTValid, mTLast, mTUser, mTDest, mTData}, saved);
            checkOutput("tready_while_stalled", 64'(sTReady & {NREQ{mTValid & ~mTReady}}), 64'(0));
            for (int k = 0; k < NREQ; k++) begin
               if (inPkt[k]) checkOutput("tready_other_while_locked", 64'(sTReady & ~(NREQ'(1) << k)), 64'(0));
            end
            if (mTValid && firstMCycle < 0) firstMCycle = cycleCnt;
            if (mTValid && mTReady) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", 64'(1), 64'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat", {19'd0, mTLast, mTUser, mTDest, mTData},
                              {19'd0, e.last, e.user, e.dest, e.data});
               end
               popCount++;
               lastPopCycle = cycleCnt;
            end
            stallPrev = mTValid && !mTReady;
            if (stallPrev) begin
               saved = {18'd0, mTValid, mTLast, mTUser, mTDest, mTData};
               stallCycles++;
            end
         end
      end
   endtask

   initial begin
      int total;
      vecCount   = 0;
      errCount   = 0;
      cycleCnt   = 0;
      mReadyPct  = 100;
      drvEnable  = 1'b0;
      forceStall = 1'b0;
      sTValid    = '0;
      sTLast     = '0;
      sTData     = '0;
      sTUser     = '0;
      sTDest     = '0;
      mTReady    = 1'b0;
      RST_N      = 1'b1;
      clearSources();
      fork
         driverLoop();
         monitorLoop();
      join_none

      // Reset values.
      #3 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("rst_m_tvalid", 64'(mTValid), 64'(0));
      checkOutput("rst_m_tlast", 64'(mTLast), 64'(0));
      checkOutput("rst_m_tdata", 64'(mTData), 64'(0));
      checkOutput("rst_m_tuser", 64'(mTUser), 64'(0));
      checkOutput("rst_m_tdest", 64'(mTDest), 64'(0));
      checkOutput("rst_grant_id", 64'(grantId), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_s_tready", 64'(sTReady), 64'(0));
      RST_N = 1'b1;

      // Requester 2 alone: 3-beat packet 0xA,0xB,0xC to destination 5.
      $display("[TB] single requester, 3-beat packet");
      addBeat(2, 32'hA, 8'h11, 4'd5, 1'b0, 0);
      addBeat(2, 32'hB, 8'h22, 4'd5, 1'b0, 0);
      addBeat(2, 32'hC, 8'h33, 4'd5, 1'b1, 0);
      buildExpected();
      mReadyPct = 100;
      drvEnable = 1'b1;
      waitDrain("s1", 200);
      checkOutput("s1_latency", 64'(firstMCycle - firstValidCycle), 64'(2));
      checkOutput("s1_consecutive", 64'(lastPopCycle - firstMCycle), 64'(2));
      checkOutput("s1_grant_id", 64'(grantId), 64'(2));
      checkOutput("s1_beats", 64'(popCount), 64'(3));

      // All four requesters offering two 2-beat packets each.
      $display("[TB] four requesters, continuous 2-beat packets");
      applyReset();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < NREQ; r++) applyStimulus(r, 2, -1, 0);
      buildExpected();
      mReadyPct = 100;
      drvEnable = 1'b1;
      waitDrain("s2", 300);
      checkOutput("s2_beats", 64'(popCount), 64'(16));
      checkOutput("s2_bubble_spacing", 64'(lastPopCycle - firstMCycle), 64'(22));

      // Master stalls for five cycles while beat 2 of 4 sits in the output register.
      $display("[TB] output stall mid-packet");
      applyReset();
      applyStimulus(1, 4, -1, 0);
      buildExpected();
      mReadyPct = 100;
      drvEnable = 1'b1;
      waitFirstPop("s3");
      forceStall = 1'b1;
      repeat (6) @(posedge CLK);
      forceStall = 1'b0;
      waitDrain("s3", 200);
      checkOutput("s3_stall_cycles", 64'(stallCycles), 64'(5));
      checkOutput("s3_beats", 64'(popCount), 64'(4));

      // Locked requester 0 pauses three cycles mid-packet while requester 1 waits.
      $display("[TB] source gap mid-packet with competing requester");
      applyReset();
      applyStimulus(0, 4, 2, 3);
      applyStimulus(1, 2, -1, 0);
      buildExpected();
      mReadyPct = 100;
      drvEnable = 1'b1;
      waitDrain("s4", 200);
      checkOutput("s4_beats", 64'(popCount), 64'(6));

      // Reset in the middle of a packet, then requesters 0 and 3 compete.
      $display("[TB] reset mid-packet");
      applyReset();
      applyStimulus(0, 4, -1, 0);
      buildExpected();
      mReadyPct = 100;
      drvEnable = 1'b1;
      waitFirstPop("s5");
      @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      checkOutput("s5_m_tvalid_async", 64'(mTValid), 64'(0));
      checkOutput("s5_m_tdata_async", 64'(mTData), 64'(0));
      checkOutput("s5_busy_async", 64'(busy), 64'(0));
      checkOutput("s5_s_tready_async", 64'(sTReady), 64'(0));
      drvEnable = 1'b0;
      clearSources();
      repeat (2) @(posedge CLK);
      applyStimulus(3, 2, -1, 0);
      applyStimulus(0, 2, -1, 0);
      buildExpected();
      @(negedge CLK);
      RST_N     = 1'b1;
      drvEnable = 1'b1;
      waitDrain("s5", 200);
      checkOutput("s5_beats", 64'(popCount), 64'(4));

      // Randomised traffic: packet lengths 1..4, occasional mid-packet gaps, random master ready.
      for (int round = 0; round < 3; round++) begin
         $display("[TB] random round %0d", round);
         applyReset();
         total = 0;
         for (int r = 0; r < NREQ; r++) begin
            int npk;
            npk = int'($urandom_range(4));
            for (int p = 0; p < npk; p++) begin
               int len, gIdx;
               len  = int'($urandom_range(1, 4));
               gIdx = (len > 1 && $urandom_range(2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
               applyStimulus(r, len, gIdx, int'($urandom_range(1, 3)));
               total += len;
            end
         end
         buildExpected();
         mReadyPct = (round == 0) ? 100 : (round == 1 ? 70 : 40);
         drvEnable = 1'b1;
         waitDrain("rand", 2000);
         checkOutput("rand_beats", 64'(popCount), 64'(total));
      end

      drvEnable = 1'b0;
      repeat (2) @(posedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
